bus_demux_1to2: RTL and testbench
=================================

// Module: bus_demux_1to2
// PURPOSE
//   Buffered 1-to-2 bus demultiplexer: routes one valid/ready input stream to one of two
//   valid/ready output streams, chosen per word by in_sel. Each output has its own DEPTH-entry
//   FIFO, so a stalled consumer on one side never blocks words bound for the other side.
//   Sits where one datapath bus fans out to two consumers (e.g. result bus -> writeback / store).
// PARAMETERS
//   WIDTH   64   data bits per word
//   DEPTH   2    entries per output FIFO; power of two, >= 2
// PORTS
//   clk          input   1                  rising-edge clock
//   reset_n      input   1                  asynchronous, active-low reset
//   in_valid     input   1                  input word present
//   in_ready     output  1                  block can accept word for output in_sel
//   in_sel       input   1                  destination: 0 -> out0, 1 -> out1; valid with in_valid
//   in_data      input   WIDTH              input word
//   out0_valid   output  1                  out0 FIFO non-empty
//   out0_ready   input   1                  out0 consumer takes head word
//   out0_data    output  WIDTH              out0 FIFO head word
//   out0_level   output  $clog2(DEPTH)+1    out0 FIFO occupancy, 0..DEPTH
//   out1_valid   output  1                  as out0
//   out1_ready   input   1                  as out0
//   out1_data    output  WIDTH              as out0
//   out1_level   output  $clog2(DEPTH)+1    as out0
// BEHAVIOUR
//   - reset_n low (async, any cycle incl. mid-transfer): both FIFOs empty, pointers 0,
//     storage cleared; outN_valid=0, outN_data=0, outN_level=0; in_ready=1 once released.
//     Words held at reset are dropped; no partial state survives.
//   - in_ready = ~fullN where N = in_sel (combinational from in_sel and registered state only;
//     no path from outN_ready to in_ready).
//   - Push: in_valid & in_ready at edge -> in_data written to FIFO[in_sel] tail, level +1.
//   - Pop: outN_valid & outN_ready at edge -> FIFO N head retired, level -1.
//   - Latency: word accepted at edge k is visible on outN_data/outN_valid after edge k
//     (1 cycle); no combinational in_data -> outN_data path.
//   - Per-output FIFO order preserved; no ordering between out0 and out1.
//   - outN_valid = (levelN != 0); outN_data = head entry, stable while valid & ~ready.
//   - Full: levelN == DEPTH -> in_ready=0 when in_sel=N, even if outN pops same cycle
//     (no full bypass). Other output unaffected.
//   - Empty: levelN == 0 -> outN_valid=0; outN_ready ignored (no underflow, level stays 0).
//   - Simultaneous push+pop on same non-full FIFO: level unchanged, both take effect.
//   - Pointers are $clog2(DEPTH) bits, wrap modulo DEPTH silently.
//   - in_sel/in_data ignored when in_valid=0; consumers may drop outN_ready any cycle.
// TESTING (WIDTH=16, DEPTH=2)
//   1. Reset: hold reset_n=0 -> all valids 0, levels 0, data 0; release -> in_ready=1.
//   2. Route: push 16'hCA35 sel=0, then 16'hE6F2 sel=1, both readys=1 -> out0_data=CA35
//      one cycle after first push, out1_data=E6F2 one cycle after second; levels return 0.
//   3. Fill/isolate: out0_ready=0, push A1,A2 sel=0 -> out0_level=2, in_ready=0 for sel=0;
//      sel=1 word B1 still accepted and popped on out1 while out0 stalls.
//   4. Full no-bypass: out0 full, out0_ready=1 and push sel=0 same cycle -> push refused,
//      A1 popped, level=1; next cycle push accepted; out0 order A1,A2,A3.
//   5. Wrap/throughput: both readys=1, 10 back-to-back words alternating sel ->
//      one accepted per cycle, all delivered in per-output order across pointer wrap.
//   6. Reset mid-op: out1 level=2, pulse reset_n low between edges -> immediate valid=0,
//      level=0; post-reset traffic correct, no stale words emerge.

Source files
------------

// File: rtl/bus_demux_1to2.sv
// Buffered 1-to-2 valid/ready demultiplexer: each input word is steered by in_sel into
// one of two independent FIFOs, so a stalled consumer never blocks the other output.
module bus_demux_1to2 #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic                     in_sel,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     out0_valid,
  input  logic                     out0_ready,
  output logic [WIDTH-1:0]         out0_data,
  output logic [$clog2(DEPTH):0]   out0_level,
  output logic                     out1_valid,
  input  logic                     out1_ready,
  output logic [WIDTH-1:0]         out1_data,
  output logic [$clog2(DEPTH):0]   out1_level
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;
  localparam logic [AW-1:0] PTR_ONE  = AW'(1);
  localparam logic [LW-1:0] LVL_ONE  = LW'(1);
  localparam logic [LW-1:0] LVL_FULL = LW'(DEPTH);

  logic [1:0]            out_ready_v;
  logic [1:0]            full_v;
  logic [1:0]            valid_v;
  logic [1:0]            push_v;
  logic [1:0]            pop_v;
  logic [1:0][WIDTH-1:0] head_data;
  logic [1:0][LW-1:0]    level_v;
  logic                  accept;

  assign out_ready_v = {out1_ready, out0_ready};

  // Ready depends only on the selected FIFO's registered fullness, never on the
  // consumer's ready, so a pop cannot free a slot for a push in the same cycle.
  assign in_ready = ~full_v[in_sel];
  assign accept   = in_valid & in_ready;

  for (genvar gi = 0; gi < 2; gi++) begin : g_fifo
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q;
    logic [AW-1:0]    rd_ptr_d;
    logic [LW-1:0]    level_q;
    logic [LW-1:0]    level_d;

    assign full_v[gi]    = (level_q == LVL_FULL);
    assign valid_v[gi]   = (level_q != '0);
    assign push_v[gi]    = accept & (in_sel == 1'(gi));
    assign pop_v[gi]     = valid_v[gi] & out_ready_v[gi];
    assign head_data[gi] = mem_q[rd_ptr_q];
    assign level_v[gi]   = level_q;

    always_comb begin
      mem_d    = mem_q;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      level_d  = level_q;
      if (push_v[gi]) begin
        mem_d[wr_ptr_q] = in_data;
        wr_ptr_d        = wr_ptr_q + PTR_ONE;
      end
      if (pop_v[gi]) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      case ({push_v[gi], pop_v[gi]})
        2'b10:   level_d = level_q + LVL_ONE;
        2'b01:   level_d = level_q - LVL_ONE;
        default: level_d = level_q;
      endcase
    end

    // Storage is cleared on reset so the idle data outputs read zero.
    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        for (int i = 0; i < DEPTH; i++) begin
          mem_q[i] <= '0;
        end
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        mem_q    <= mem_d;
        wr_ptr_q <= wr_ptr_d;
        rd_ptr_q <= rd_ptr_d;
        level_q  <= level_d;
      end
    end
  end

  assign out0_valid = valid_v[0];
  assign out0_data  = head_data[0];
  assign out0_level = level_v[0];
  assign out1_valid = valid_v[1];
  assign out1_data  = head_data[1];
  assign out1_level = level_v[1];

endmodule

// File: tb/tb_bus_demux_1to2.sv
// Bench for bus_demux_1to2 (WIDTH=16, DEPTH=2): hand-written vector table, corner
// sequences and random traffic, all checked against a per-output queue model.
module tb_bus_demux_1to2;

  localparam int WIDTH = 16;
  localparam int DEPTH = 2;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             in_valid;
  logic             in_ready;
  logic             in_sel;
  logic [WIDTH-1:0] in_data;
  logic             out0_valid;
  logic             out0_ready;
  logic [WIDTH-1:0] out0_data;
  logic [1:0]       out0_level;
  logic             out1_valid;
  logic             out1_ready;
  logic [WIDTH-1:0] out1_data;
  logic [1:0]       out1_level;

  int n_checks = 0;
  int n_pass   = 0;

  logic [WIDTH-1:0] q0 [$];
  logic [WIDTH-1:0] q1 [$];

  typedef struct {
    logic        v;
    logic        s;
    logic [15:0] d;
    logic        r0;
    logic        r1;
    logic        rdy;
    logic        v0;
    logic [15:0] d0;
    logic [1:0]  l0;
    logic        v1;
    logic [15:0] d1;
    logic [1:0]  l1;
  } vec_t;

  vec_t tbl [14];

  always #5 clk = ~clk;

  bus_demux_1to2 #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_sel     (in_sel),
    .in_data    (in_data),
    .out0_valid (out0_valid),
    .out0_ready (out0_ready),
    .out0_data  (out0_data),
    .out0_level (out0_level),
    .out1_valid (out1_valid),
    .out1_ready (out1_ready),
    .out1_data  (out1_data),
    .out1_level (out1_level)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Reference: the observable state is just the two ordered word queues.
  task automatic model_check();
    int n0 = q0.size();
    int n1 = q1.size();
    chk("in_ready",   32'(in_ready),   32'(((in_sel ? n1 : n0) < DEPTH)));
    chk("out0_valid", 32'(out0_valid), 32'(n0 != 0));
    chk("out0_level", 32'(out0_level), 32'(n0));
    chk("out1_valid", 32'(out1_valid), 32'(n1 != 0));
    chk("out1_level", 32'(out1_level), 32'(n1));
    if (n0 != 0) chk("out0_data", 32'(out0_data), 32'(q0[0]));
    if (n1 != 0) chk("out1_data", 32'(out1_data), 32'(q1[0]));
  endtask

  task automatic drive(input logic v, input logic s, input logic [15:0] d,
                       input logic r0, input logic r1);
    in_valid   = v;
    in_sel     = s;
    in_data    = d;
    out0_ready = r0;
    out1_ready = r1;
    #1;
    model_check();
  endtask

  task automatic advance();
    int  n0  = q0.size();
    int  n1  = q1.size();
    bit  acc = in_valid && ((in_sel ? n1 : n0) < DEPTH);
    if (n0 != 0 && out0_ready) void'(q0.pop_front());
    if (n1 != 0 && out1_ready) void'(q1.pop_front());
    if (acc) begin
      if (in_sel) q1.push_back(in_data);
      else        q0.push_back(in_data);
    end
    $display("cycle t=%0t v=%0b sel=%0b data=%04h acc=%0b lvl0=%0d lvl1=%0d",
             $time, in_valid, in_sel, in_data, acc, q0.size(), q1.size());
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic step(input logic v, input logic s, input logic [15:0] d,
                      input logic r0, input logic r1);
    drive(v, s, d, r0, r1);
    advance();
  endtask

  initial begin
    //            v     s     data      r0    r1  | rdy  v0    d0       l0  v1    d1       l1
    tbl[0]  = '{1'b1, 1'b0, 16'hCA35, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0};
    tbl[1]  = '{1'b1, 1'b1, 16'hE6F2, 1'b1, 1'b1, 1'b1, 1'b1, 16'hCA35, 2'd1, 1'b0, 16'h0000, 2'd0};
    tbl[2]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b1, 16'hE6F2, 2'd1};
    tbl[3]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0};
    tbl[4]  = '{1'b1, 1'b0, 16'h00A1, 1'b0, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0};
    tbl[5]  = '{1'b1, 1'b0, 16'h00A2, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A1, 2'd1, 1'b0, 16'h0000, 2'd0};
    tbl[6]  = '{1'b1, 1'b0, 16'h00A9, 1'b0, 1'b1, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0, 16'h0000, 2'd0};
    tbl[7]  = '{1'b1, 1'b1, 16'h00B1, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A1, 2'd2, 1'b0, 16'h0000, 2'd0};
    tbl[8]  = '{1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A1, 2'd2, 1'b1, 16'h00B1, 2'd1};
    tbl[9]  = '{1'b1, 1'b0, 16'h00A3, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A1, 2'd2, 1'b0, 16'h0000, 2'd0};
    tbl[10] = '{1'b1, 1'b0, 16'h00A3, 1'b0, 1'b1, 1'b1, 1'b1, 16'h00A2, 2'd1, 1'b0, 16'h0000, 2'd0};
    tbl[11] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b1, 16'h00A2, 2'd2, 1'b0, 16'h0000, 2'd0};
    tbl[12] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 16'h00A3, 2'd1, 1'b0, 16'h0000, 2'd0};
    tbl[13] = '{1'b0, 1'b0, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b0, 16'h0000, 2'd0, 1'b0, 16'h0000, 2'd0};

    reset_n    = 1'b0;
    in_valid   = 1'b0;
    in_sel     = 1'b0;
    in_data    = '0;
    out0_ready = 1'b0;
    out1_ready = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst out0_valid", 32'(out0_valid), 32'd0);
    chk("rst out1_valid", 32'(out1_valid), 32'd0);
    chk("rst out0_level", 32'(out0_level), 32'd0);
    chk("rst out1_level", 32'(out1_level), 32'd0);
    chk("rst out0_data",  32'(out0_data),  32'd0);
    chk("rst out1_data",  32'(out1_data),  32'd0);
    reset_n = 1'b1;
    @(negedge clk);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("post-rst in_ready sel0", 32'(in_ready), 32'd1);
    drive(1'b0, 1'b1, 16'h0, 1'b0, 1'b0);
    chk("post-rst in_ready sel1", 32'(in_ready), 32'd1);
    advance();

    // Route, fill/isolate and full no-bypass vectors
    for (int i = 0; i < 14; i++) begin
      drive(tbl[i].v, tbl[i].s, tbl[i].d, tbl[i].r0, tbl[i].r1);
      chk($sformatf("tbl[%0d] in_ready", i),   32'(in_ready),   32'(tbl[i].rdy));
      chk($sformatf("tbl[%0d] out0_valid", i), 32'(out0_valid), 32'(tbl[i].v0));
      chk($sformatf("tbl[%0d] out0_level", i), 32'(out0_level), 32'(tbl[i].l0));
      chk($sformatf("tbl[%0d] out1_valid", i), 32'(out1_valid), 32'(tbl[i].v1));
      chk($sformatf("tbl[%0d] out1_level", i), 32'(out1_level), 32'(tbl[i].l1));
      if (tbl[i].v0) chk($sformatf("tbl[%0d] out0_data", i), 32'(out0_data), 32'(tbl[i].d0));
      if (tbl[i].v1) chk($sformatf("tbl[%0d] out1_data", i), 32'(out1_data), 32'(tbl[i].d1));
      advance();
    end

    // Back-to-back alternating traffic across pointer wrap, one word per cycle
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 1'(i % 2), 16'h5000 + 16'(i), 1'b1, 1'b1);
      chk($sformatf("b2b[%0d] in_ready", i), 32'(in_ready), 32'd1);
      advance();
    end
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Asynchronous reset between edges with out1 full
    step(1'b1, 1'b1, 16'h7711, 1'b1, 1'b0);
    step(1'b1, 1'b1, 16'h7722, 1'b1, 1'b0);
    drive(1'b0, 1'b1, 16'h0, 1'b1, 1'b0);
    chk("pre-rst out1_level", 32'(out1_level), 32'd2);
    #1 reset_n = 1'b0;
    #1;
    chk("mid-rst out1_valid", 32'(out1_valid), 32'd0);
    chk("mid-rst out1_level", 32'(out1_level), 32'd0);
    chk("mid-rst out1_data",  32'(out1_data),  32'd0);
    q0.delete();
    q1.delete();
    #1 reset_n = 1'b1;
    @(negedge clk);
    step(1'b1, 1'b1, 16'h8801, 1'b1, 1'b1);
    step(1'b1, 1'b1, 16'h8802, 1'b1, 1'b1);
    repeat (3) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);

    // Random traffic against the queue model
    for (int i = 0; i < 400; i++) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom),
           1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 2) != 0));
    end
    repeat (4) step(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b1);
    chk("drained out0_level", 32'(out0_level), 32'd0);
    chk("drained out1_level", 32'(out1_level), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
